zeroheti_obi_arbiter: RTL and testbench

- N:1 OBI arbiter that shares one OBI subordinate, such as an SRAM bank or the APB bridge, between several OBI managers (debug SBA, instruction fetch, data port).
- Round-robin with request locking, so address and control stay stable until grant, as OBI requires.
- Tracks outstanding transactions in an in-order index FIFO and routes each response back to its issuing manager.
- Sits between the manager ports and a single subordinate, where a full crossbar is unnecessary.

---
 rtl/zeroheti_pkg.sv | 14 +
 rtl/zeroheti_idx_fifo.sv | 65 ++++++
 rtl/zeroheti_obi_arbiter.sv | 157 +++++++++++++++
 tb/tb_zeroheti_obi_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg
//   Shared constants and helpers for the zeroheti OBI interconnect blocks.
//   ObiAddrWidth / ObiDataWidth : default OBI address and data widths
//   idx_width()                 : bits needed to index n items (at least 1)
package zeroheti_pkg;

   localparam int unsigned ObiAddrWidth = 32;
   localparam int unsigned ObiDataWidth = 32;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/zeroheti_idx_fifo.sv
// zeroheti_idx_fifo
//   In-order FIFO of manager indices for granted-but-unanswered transactions.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write data_i (caller guarantees not full)
//   pop_i        : drop head entry (caller guarantees not empty)
//   data_i       : index to enqueue
//   data_o       : head index
//   full_o       : count == Depth
//   empty_o      : count == 0
//   count_o      : number of stored entries
module zeroheti_idx_fifo
   import zeroheti_pkg::*;
#(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 2,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   localparam int unsigned PtrW = idx_width(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/zeroheti_obi_arbiter.sv
// zeroheti_obi_arbiter
//   N:1 round-robin OBI arbiter with request locking. Shares one subordinate
//   between NumMgr managers and routes in-order responses back to the issuer.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   mgr_req_i/gnt_o    : per-manager request / zero-cycle grant
//   mgr_addr_i/we_i/be_i/wdata_i : packed per-manager request payload
//   mgr_rvalid_o/err_o : response valid / error, to the issuing manager only
//   mgr_rdata_o        : subordinate read data broadcast to every slice
//   sbr_*              : single subordinate port
//   unexp_rsp_o        : sticky, response seen with nothing outstanding
module zeroheti_obi_arbiter
   import zeroheti_pkg::*;
#(
   parameter int unsigned NumMgr    = 3,
   parameter int unsigned AddrWidth = ObiAddrWidth,
   parameter int unsigned DataWidth = ObiDataWidth,
   parameter int unsigned MaxTrans  = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NumMgr-1:0]                 mgr_req_i,
   output logic [NumMgr-1:0]                 mgr_gnt_o,
   input  logic [NumMgr*AddrWidth-1:0]       mgr_addr_i,
   input  logic [NumMgr-1:0]                 mgr_we_i,
   input  logic [NumMgr*(DataWidth/8)-1:0]   mgr_be_i,
   input  logic [NumMgr*DataWidth-1:0]       mgr_wdata_i,
   output logic [NumMgr-1:0]                 mgr_rvalid_o,
   output logic [NumMgr*DataWidth-1:0]       mgr_rdata_o,
   output logic [NumMgr-1:0]                 mgr_err_o,
   output logic                              sbr_req_o,
   input  logic                              sbr_gnt_i,
   output logic [AddrWidth-1:0]              sbr_addr_o,
   output logic                              sbr_we_o,
   output logic [DataWidth/8-1:0]            sbr_be_o,
   output logic [DataWidth-1:0]              sbr_wdata_o,
   input  logic                              sbr_rvalid_i,
   input  logic [DataWidth-1:0]              sbr_rdata_i,
   input  logic                              sbr_err_i,
   output logic                              unexp_rsp_o
);

   localparam int unsigned IdxW = idx_width(NumMgr);
   localparam int unsigned BeW  = DataWidth / 8;
   localparam int unsigned CntW = $clog2(MaxTrans + 1);

   logic [IdxW-1:0] rr_ptr_q;
   logic [IdxW-1:0] lock_idx_q;
   logic            lock_q;
   logic            unexp_q;
   logic [IdxW-1:0] sel;
   logic [IdxW-1:0] head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CntW-1:0] fifo_count;
   logic            hs;
   logic            rsp;
   logic            stray;

   // Locked request wins outright; otherwise first requester at or after rr_ptr.
   always_comb begin
      logic            found;
      int unsigned     cand;
      logic [IdxW-1:0] cand_idx;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      sel      = lock_idx_q;
      if (!lock_q) begin
         sel = rr_ptr_q;
         for (int unsigned i = 0; i < NumMgr; i++) begin
            cand     = (32'(rr_ptr_q) + i) % NumMgr;
            cand_idx = IdxW'(cand);
            if (!found && mgr_req_i[cand_idx]) begin
               sel   = cand_idx;
               found = 1'b1;
            end
         end
      end
   end

   // Issue gated on the registered full flag only, so a same-cycle pop
   // never unblocks it combinationally.
   assign sbr_req_o = !rst_i && (|mgr_req_i) && !fifo_full;
   assign hs        = sbr_req_o && sbr_gnt_i;
   assign rsp       = sbr_rvalid_i && !fifo_empty;
   assign stray     = sbr_rvalid_i && (fifo_count == '0);

   always_comb begin
      sbr_addr_o  = '0;
      sbr_we_o    = 1'b0;
      sbr_be_o    = '0;
      sbr_wdata_o = '0;
      mgr_gnt_o   = '0;
      if (sbr_req_o) begin
         sbr_addr_o  = mgr_addr_i[32'(sel)*AddrWidth +: AddrWidth];
         sbr_we_o    = mgr_we_i[sel];
         sbr_be_o    = mgr_be_i[32'(sel)*BeW +: BeW];
         sbr_wdata_o = mgr_wdata_i[32'(sel)*DataWidth +: DataWidth];
      end
      if (hs) mgr_gnt_o[sel] = 1'b1;
   end

   always_comb begin
      mgr_rvalid_o = '0;
      mgr_err_o    = '0;
      if (rsp) begin
         mgr_rvalid_o[head] = 1'b1;
         mgr_err_o[head]    = sbr_err_i;
      end
   end

   assign mgr_rdata_o = rst_i ? '0 : {NumMgr{sbr_rdata_i}};
   assign unexp_rsp_o = unexp_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         unexp_q    <= 1'b0;
      end else begin
         // A stalled request holds the lock even if issue is blocked by a
         // full FIFO, since neither branch fires while sbr_req_o is low.
         if (hs) begin
            lock_q   <= 1'b0;
            rr_ptr_q <= IdxW'((32'(sel) + 1) % NumMgr);
         end else if (sbr_req_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
         end
         if (stray) unexp_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!stray)
         else $warning("zeroheti_obi_arbiter: response with no outstanding transaction dropped");
      end
   end

   zeroheti_idx_fifo #(
      .Depth (MaxTrans),
      .Width (IdxW)
   ) u_idx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (hs),
      .pop_i   (rsp),
      .data_i  (sel),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

endmodule

// File: tb/tb_zeroheti_obi_arbiter.sv
module tb_zeroheti_obi_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;
   localparam int unsigned MT = 2;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0]    mgr_req, mgr_gnt, mgr_we, mgr_rvalid, mgr_err;
   logic [N*AW-1:0] mgr_addr;
   logic [N*BW-1:0] mgr_be;
   logic [N*DW-1:0] mgr_wdata, mgr_rdata;
   logic            sbr_req, sbr_gnt, sbr_we, sbr_rvalid, sbr_err, unexp;
   logic [AW-1:0]   sbr_addr;
   logic [BW-1:0]   sbr_be;
   logic [DW-1:0]   sbr_wdata, sbr_rdata;

   always #5 clk = ~clk;

   zeroheti_obi_arbiter #(
      .NumMgr    (N),
      .AddrWidth (AW),
      .DataWidth (DW),
      .MaxTrans  (MT)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .mgr_req_i    (mgr_req),
      .mgr_gnt_o    (mgr_gnt),
      .mgr_addr_i   (mgr_addr),
      .mgr_we_i     (mgr_we),
      .mgr_be_i     (mgr_be),
      .mgr_wdata_i  (mgr_wdata),
      .mgr_rvalid_o (mgr_rvalid),
      .mgr_rdata_o  (mgr_rdata),
      .mgr_err_o    (mgr_err),
      .sbr_req_o    (sbr_req),
      .sbr_gnt_i    (sbr_gnt),
      .sbr_addr_o   (sbr_addr),
      .sbr_we_o     (sbr_we),
      .sbr_be_o     (sbr_be),
      .sbr_wdata_o  (sbr_wdata),
      .sbr_rvalid_i (sbr_rvalid),
      .sbr_rdata_i  (sbr_rdata),
      .sbr_err_i    (sbr_err),
      .unexp_rsp_o  (unexp)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Manager-side request state held by the bench (stable until granted).
   bit          pend [N];
   logic [AW-1:0] pa [N];
   logic          pwe [N];
   logic [BW-1:0] pbe [N];
   logic [DW-1:0] pwd [N];

   // Reference model: priority starts just after the last winner; a
   // presented-but-ungranted manager keeps the port until it is granted.
   int unsigned last_win;
   int          lock_idx;
   int unsigned outstanding;
   bit          exp_unexp;
   int unsigned exp_q[$];    // scoreboard: issuing manager per transaction
   int unsigned dut_log[$];  // manager indices the DUT actually granted

   function automatic void check(input string name, input logic [127:0] act,
                                 input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int unsigned model_sel();
      if (lock_idx >= 0) return lock_idx;
      for (int unsigned k = 1; k <= N; k++) begin
         if (mgr_req[(last_win + k) % N]) return (last_win + k) % N;
      end
      return 0;
   endfunction

   task automatic drive();
      for (int unsigned k = 0; k < N; k++) begin
         mgr_req[k]              = pend[k];
         mgr_addr[k*AW +: AW]    = pa[k];
         mgr_we[k]               = pwe[k];
         mgr_be[k*BW +: BW]      = pbe[k];
         mgr_wdata[k*DW +: DW]   = pwd[k];
      end
   endtask

   task automatic new_req(input int unsigned k, input logic [AW-1:0] addr, input logic we);
      pend[k] = 1'b1;
      pa[k]   = addr;
      pwe[k]  = we;
      pbe[k]  = BW'($urandom);
      pwd[k]  = $urandom;
   endtask

   // One clock: inputs already driven; check combinational outputs at the
   // falling edge, then advance the model at the rising edge.
   task automatic step();
      int unsigned sel;
      bit ereq, hs, rsp;
      @(negedge clk);
      sel  = model_sel();
      ereq = (|mgr_req) && (outstanding < MT);
      check("sbr_req", sbr_req, ereq);
      check("mgr_gnt", mgr_gnt, (ereq && sbr_gnt) ? (128'd1 << sel) : 128'd0);
      if (ereq) begin
         check("sbr_addr", sbr_addr, pa[sel]);
         check("sbr_we_be_wdata", {sbr_we, sbr_be, sbr_wdata}, {pwe[sel], pbe[sel], pwd[sel]});
      end else begin
         check("payload_idle", {sbr_addr, sbr_we, sbr_be, sbr_wdata}, 128'd0);
      end
      check("unexp_rsp", unexp, exp_unexp);
      for (int unsigned k = 0; k < N; k++) if (mgr_gnt[k]) dut_log.push_back(k);
      hs  = ereq && sbr_gnt;
      rsp = sbr_rvalid && (outstanding > 0);
      if (sbr_rvalid && outstanding == 0) exp_unexp = 1'b1;
      @(posedge clk);
      if (hs) begin
         exp_q.push_back(sel);
         last_win  = sel;
         lock_idx  = -1;
         pend[sel] = 1'b0;
      end else if (ereq) begin
         lock_idx = sel;
      end
      outstanding = outstanding + (hs ? 1 : 0) - (rsp ? 1 : 0);
      #1;
      drive();
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      mgr_req    = '1;
      sbr_gnt    = 1'b1;
      sbr_rvalid = 1'b1;
      sbr_rdata  = 32'hA5A5_A5A5;
      @(negedge clk);
      check("rst_sbr_req", sbr_req, 0);
      check("rst_gnt", mgr_gnt, 0);
      check("rst_rvalid_err", {mgr_rvalid, mgr_err}, 0);
      check("rst_rdata", mgr_rdata, 0);
      check("rst_payload", {sbr_addr, sbr_we, sbr_be, sbr_wdata}, 0);
      check("rst_unexp", unexp, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         pend[k] = 1'b0; pa[k] = '0; pwe[k] = 1'b0; pbe[k] = '0; pwd[k] = '0;
      end
      drive();
      sbr_gnt     = 1'b0;
      sbr_rvalid  = 1'b0;
      sbr_err     = 1'b0;
      last_win    = N - 1;
      lock_idx    = -1;
      outstanding = 0;
      exp_unexp   = 1'b0;
      exp_q.delete();
      dut_log.delete();
   endtask

   // Response monitor: every routed response is matched to the oldest issue.
   always @(negedge clk) begin
      if (!rst && (sbr_rvalid || mgr_rvalid != '0)) begin
         if (exp_q.size() == 0) begin
            check("stray_not_routed", {mgr_rvalid, mgr_err}, 0);
         end else begin
            automatic int unsigned m = exp_q.pop_front();
            check("rvalid_route", mgr_rvalid, 128'd1 << m);
            check("err_route", mgr_err, sbr_err ? (128'd1 << m) : 128'd0);
            check("rdata_bcast", mgr_rdata, {N{sbr_rdata}});
         end
      end
   end

   initial begin
      rst = 1'b1;
      sbr_err = 1'b0;
      do_reset();

      // Single manager read, response next cycle.
      new_req(1, 32'h100, 1'b0);
      drive();
      sbr_gnt = 1'b1;
      step();
      check("single_grant_idx", dut_log.size() == 1 ? dut_log[0] : 99, 1);
      sbr_rvalid = 1'b1;
      sbr_rdata  = 32'hDEAD_BEEF;
      step();
      sbr_rvalid = 1'b0;
      step();

      // Round robin with all three requesting continuously.
      do_reset();
      for (int unsigned k = 0; k < N; k++) new_req(k, 32'h1000 + 4*k, 1'b1);
      drive();
      sbr_gnt = 1'b1;
      for (int c = 0; c < 6; c++) begin
         sbr_rvalid = (outstanding > 0);
         sbr_rdata  = $urandom;
         step();
         for (int unsigned k = 0; k < N; k++) if (!pend[k]) new_req(k, 32'h1000 + 4*k, 1'b1);
         drive();
      end
      begin
         int unsigned rr_exp [6] = '{0, 1, 2, 0, 1, 2};
         for (int i = 0; i < 6; i++)
            check("rr_order", (i < dut_log.size()) ? dut_log[i] : 99, rr_exp[i]);
      end

      // Lock: manager 2 stalls, manager 0 arrives, 2 still wins.
      do_reset();
      new_req(2, 32'h2222_0000, 1'b0);
      drive();
      for (int c = 0; c < 3; c++) step();
      new_req(0, 32'h0000_0040, 1'b1);
      drive();
      step();
      sbr_gnt = 1'b1;
      step();
      step();
      check("lock_first", (dut_log.size() > 0) ? dut_log[0] : 99, 2);
      check("lock_second", (dut_log.size() > 1) ? dut_log[1] : 99, 0);

      // Full: two grants with responses withheld block the third.
      do_reset();
      for (int unsigned k = 0; k < N; k++) new_req(k, 32'h3000 + 4*k, 1'b0);
      drive();
      sbr_gnt = 1'b1;
      step();
      step();
      step();
      sbr_rvalid = 1'b1;
      sbr_rdata  = 32'h1111_0000;
      step();
      sbr_rvalid = 1'b0;
      step();
      check("full_third_grant", (dut_log.size() > 2) ? dut_log[2] : 99, 2);
      sbr_gnt = 1'b0;
      sbr_rvalid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         sbr_rdata = $urandom;
         step();
      end
      sbr_rvalid = 1'b0;

      // Error routed to manager 1, then a stray response.
      do_reset();
      new_req(1, 32'h4444, 1'b0);
      drive();
      sbr_gnt = 1'b1;
      step();
      sbr_gnt    = 1'b0;
      sbr_rvalid = 1'b1;
      sbr_err    = 1'b1;
      step();
      sbr_err = 1'b0;
      step();
      sbr_rvalid = 1'b0;
      for (int c = 0; c < 3; c++) step();

      // Reset with two outstanding, then a stray response and fresh grant.
      do_reset();
      new_req(0, 32'h5000, 1'b0);
      new_req(1, 32'h5004, 1'b0);
      drive();
      sbr_gnt = 1'b1;
      step();
      step();
      do_reset();
      sbr_rvalid = 1'b1;
      step();
      sbr_rvalid = 1'b0;
      new_req(1, 32'h6004, 1'b1);
      new_req(2, 32'h6008, 1'b1);
      drive();
      sbr_gnt = 1'b1;
      step();
      check("post_reset_first", (dut_log.size() > 0) ? dut_log[0] : 99, 1);
      sbr_gnt = 1'b0;
      sbr_rvalid = 1'b1;
      step();
      sbr_rvalid = 1'b0;

      // Randomised traffic.
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         for (int unsigned k = 0; k < N; k++)
            if (!pend[k] && ($urandom_range(0, 9) < 4)) new_req(k, $urandom, 1'($urandom));
         drive();
         sbr_gnt    = ($urandom_range(0, 9) < 6);
         sbr_rvalid = (outstanding > 0) && ($urandom_range(0, 1) == 1);
         sbr_err    = ($urandom_range(0, 7) == 0);
         sbr_rdata  = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
